// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
//
// Front-panel button controller. A single free-running prescaler produces a
// sample tick that all buttons share. Each button is synchronized, debounced
// on ticks, and classified by a small per-button state machine into press,
// release, long-press and auto-repeat events. Each event raises a pending
// flag. A round-robin arbiter drains the flags into one valid/ready event
// stream.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   btn_raw      raw asynchronous button inputs, 1 = pressed
//   btn_level    debounced level per button
//   event_valid  event slot holds an event
//   event_ready  consumer accepts the event when high together with event_valid
//   event_id     button index of the event in the slot
//   event_code   0 = press, 1 = release, 2 = long, 3 = repeat
//   overrun      one-cycle pulse when a raised event was dropped
// ---------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 100_000,
  parameter int STABLE_TICKS = 5,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  localparam int ID_W        = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [ID_W-1:0]    event_id,
  output logic [1:0]         event_code,
  output logic               overrun
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int DEB_W  = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int RPT_W  = $clog2(REPEAT_TICKS + 1);

  // Pending-bit positions match the event code values.
  localparam int CODE_PRESS   = 0;
  localparam int CODE_RELEASE = 1;
  localparam int CODE_LONG    = 2;
  localparam int CODE_REPEAT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEATING
  } btn_state_t;

  // -------------------------------------------------------------------------
  // Input synchronizer (two flops per bit)
  // -------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync_reg  <= sync1_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Shared sample-tick prescaler
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] presc_reg;
  logic             tick;

  assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Arbiter signals shared with the per-button logic
  // -------------------------------------------------------------------------
  logic [3:0]         pend_vec [NUM_BTN];
  logic [NUM_BTN-1:0] btn_pend;
  logic [NUM_BTN-1:0] drop;
  logic               slot_free;
  logic               load;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [1:0]         grant_code;
  logic [3:0]         grant_onehot;

  // -------------------------------------------------------------------------
  // Per-button debounce, classification and pending flags
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
    logic              level_reg;
    logic              flip;
    btn_state_t        state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [RPT_W-1:0]  rpt_cnt_reg, rpt_cnt_next;
    logic              ev_press, ev_release, ev_long, ev_repeat;
    logic [3:0]        pend_reg;
    logic [3:0]        set_bits;
    logic [3:0]        clr_bits;

    // Debounce: the level flips on the tick that sees the STABLE_TICKS-th
    // consecutive sample differing from the current level.
    always_comb begin
      deb_cnt_next = deb_cnt_reg;
      flip         = 1'b0;
      if (tick) begin
        if (sync_reg[gi] != level_reg) begin
          if (deb_cnt_reg == DEB_W'(STABLE_TICKS - 1)) begin
            flip         = 1'b1;
            deb_cnt_next = '0;
          end else begin
            deb_cnt_next = deb_cnt_reg + 1'b1;
          end
        end else begin
          deb_cnt_next = '0;
        end
      end
    end

    // Classification FSM. A falling level always wins over a long/repeat
    // that would otherwise fire on the same tick.
    always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      rpt_cnt_next  = rpt_cnt_reg;
      ev_press      = 1'b0;
      ev_release    = 1'b0;
      ev_long       = 1'b0;
      ev_repeat     = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (flip && !level_reg) begin
            state_next    = ST_HELD;
            hold_cnt_next = '0;
            rpt_cnt_next  = '0;
            ev_press      = 1'b1;
          end
        end
        ST_HELD: begin
          if (flip && level_reg) begin
            state_next    = ST_IDLE;
            hold_cnt_next = '0;
            rpt_cnt_next  = '0;
            ev_release    = 1'b1;
          end else if (tick) begin
            if (hold_cnt_reg == HOLD_W'(LONG_TICKS - 1)) begin
              // Counter parks at its threshold while repeating.
              hold_cnt_next = HOLD_W'(LONG_TICKS);
              rpt_cnt_next  = '0;
              state_next    = ST_REPEATING;
              ev_long       = 1'b1;
            end else begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
        end
        ST_REPEATING: begin
          if (flip && level_reg) begin
            state_next    = ST_IDLE;
            hold_cnt_next = '0;
            rpt_cnt_next  = '0;
            ev_release    = 1'b1;
          end else if (tick) begin
            if (rpt_cnt_reg == RPT_W'(REPEAT_TICKS - 1)) begin
              rpt_cnt_next = '0;
              ev_repeat    = 1'b1;
            end else begin
              rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
          rpt_cnt_next  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt_reg  <= '0;
        level_reg    <= 1'b0;
        state_reg    <= ST_IDLE;
        hold_cnt_reg <= '0;
        rpt_cnt_reg  <= '0;
      end else begin
        deb_cnt_reg  <= deb_cnt_next;
        level_reg    <= level_reg ^ flip;
        state_reg    <= state_next;
        hold_cnt_reg <= hold_cnt_next;
        rpt_cnt_reg  <= rpt_cnt_next;
      end
    end

    // Pending flags, one per code. A set colliding with a bit that the
    // arbiter is consuming this cycle is simply re-armed.
    always_comb begin
      set_bits               = 4'b0000;
      set_bits[CODE_PRESS]   = ev_press;
      set_bits[CODE_RELEASE] = ev_release;
      set_bits[CODE_LONG]    = ev_long;
      set_bits[CODE_REPEAT]  = ev_repeat;
    end

    assign clr_bits     = (load && (grant_idx == ID_W'(gi))) ? grant_onehot : 4'b0000;
    assign drop[gi]     = |(set_bits & pend_reg & ~clr_bits);
    assign btn_pend[gi] = |pend_reg;
    assign pend_vec[gi] = pend_reg;
    assign btn_level[gi] = level_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_reg <= 4'b0000;
      end else begin
        pend_reg <= (pend_reg & ~clr_bits) | set_bits;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter and output slot
  // -------------------------------------------------------------------------
  logic [ID_W-1:0] ptr_reg;
  logic            valid_reg;
  logic [ID_W-1:0] id_reg;
  logic [1:0]      code_reg;
  logic            overrun_reg;

  assign slot_free = !valid_reg || event_ready;
  assign load      = slot_free && grant_found;

  // Search starts one past the last granted button and wraps, so the last
  // granted button is considered last.
  always_comb begin
    int cand_i;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_i      = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand_i = int'(ptr_reg) + k;
      if (cand_i >= NUM_BTN) begin
        cand_i = cand_i - NUM_BTN;
      end
      if (!grant_found && btn_pend[cand_i[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_i[ID_W-1:0];
      end
    end
  end

  // Within the granted button: press > long > repeat > release.
  always_comb begin
    logic [3:0] sel;
    sel          = pend_vec[grant_idx];
    grant_code   = 2'(CODE_RELEASE);
    grant_onehot = 4'b0000;
    if (sel[CODE_PRESS]) begin
      grant_code               = 2'(CODE_PRESS);
      grant_onehot[CODE_PRESS] = 1'b1;
    end else if (sel[CODE_LONG]) begin
      grant_code              = 2'(CODE_LONG);
      grant_onehot[CODE_LONG] = 1'b1;
    end else if (sel[CODE_REPEAT]) begin
      grant_code                = 2'(CODE_REPEAT);
      grant_onehot[CODE_REPEAT] = 1'b1;
    end else if (sel[CODE_RELEASE]) begin
      grant_code                 = 2'(CODE_RELEASE);
      grant_onehot[CODE_RELEASE] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      id_reg      <= '0;
      code_reg    <= 2'b00;
      ptr_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= |drop;
      if (slot_free) begin
        if (grant_found) begin
          valid_reg <= 1'b1;
          id_reg    <= grant_idx;
          code_reg  <= grant_code;
          ptr_reg   <= grant_idx;
        end else begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign event_valid = valid_reg;
  assign event_id    = id_reg;
  assign event_code  = code_reg;
  assign overrun     = overrun_reg;

endmodule
